// File: rtl/avalon_mem_if_arbiter_if.sv
// Avalon-MM command/response bundle shared by the arbiter's requester and memory ports.
// The master modport issues commands; the slave modport accepts them and returns stalls and read data.
interface avalon_mem_if_arbiter_if #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 27,
  parameter int BURST_CNT_WIDTH = 7
);
  logic                       read;
  logic                       write;
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic                       waitrequest;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;

  modport master (
    output read, write, address, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_if_arbiter.sv
// Two-port burst-aware Avalon-MM arbiter with write-burst locking and in-order read response steering.
// Define AVALON_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; fixed priority (port 0) otherwise.
module avalon_mem_if_arbiter #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 27,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RD_TAG_DEPTH    = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  avalon_mem_if_arbiter_if.slave          a0,
  avalon_mem_if_arbiter_if.slave          a1,
  avalon_mem_if_arbiter_if.master         m,
  output logic                            err_orphan_rsp
);

  localparam int PTR_W = $clog2(RD_TAG_DEPTH);
  localparam logic [BURST_CNT_WIDTH-1:0] ONE = BURST_CNT_WIDTH'(1);

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t                     state_q, state_d;
  logic                       lock_q, lock_d;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [BURST_CNT_WIDTH-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [PTR_W:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                       err_q, err_d;
  logic                       fifo_port_q [RD_TAG_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] fifo_len_q  [RD_TAG_DEPTH];
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
  logic                       last_grant_q, last_grant_d;
`endif

  logic                       fifo_full, fifo_empty;
  logic                       elig0, elig1, grant_valid, gsel;
  logic                       sel_read, sel_write;
  logic [BURST_CNT_WIDTH-1:0] sel_burstcount;
  logic                       cmd_read, cmd_write, accept, push, pop;
  logic                       head_port, rsp_valid;
  logic [BURST_CNT_WIDTH-1:0] head_len;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Arbitration and command mux; a read only competes while the tag FIFO has room
  always_comb begin
    elig0       = a0.write | (a0.read & ~fifo_full);
    elig1       = a1.write | (a1.read & ~fifo_full);
    gsel        = 1'b0;
    grant_valid = 1'b0;
    if (state_q == WR_BURST) begin
      gsel        = lock_q;
      grant_valid = lock_q ? a1.write : a0.write;
    end else begin
      grant_valid = elig0 | elig1;
      if (elig0 && elig1) begin
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
        gsel = ~last_grant_q;
`else
        gsel = 1'b0;
`endif
      end else begin
        gsel = elig1;
      end
    end

    sel_read       = gsel ? a1.read       : a0.read;
    sel_write      = gsel ? a1.write      : a0.write;
    sel_burstcount = gsel ? a1.burstcount : a0.burstcount;

    cmd_write = reset_n & grant_valid & sel_write;
    cmd_read  = reset_n & grant_valid & (state_q == IDLE) & ~sel_write & sel_read;
    accept    = (cmd_read | cmd_write) & ~m.waitrequest;
    push      = accept & cmd_read;

    m.read         = cmd_read;
    m.write        = cmd_write;
    m.address      = gsel ? a1.address    : a0.address;
    m.burstcount   = sel_burstcount;
    m.writedata    = gsel ? a1.writedata  : a0.writedata;
    m.byteenable   = gsel ? a1.byteenable : a0.byteenable;
    a0.waitrequest = ~(reset_n & grant_valid & ~gsel) | m.waitrequest;
    a1.waitrequest = ~(reset_n & grant_valid &  gsel) | m.waitrequest;
  end

  // Burst lock FSM; the first beat is taken in IDLE, the remaining beats in WR_BURST
  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    beats_left_d = beats_left_q;
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = gsel;
`endif
          if (cmd_write && sel_burstcount > ONE) begin
            state_d      = WR_BURST;
            lock_d       = gsel;
            beats_left_d = sel_burstcount - ONE;
          end
        end
      end
      WR_BURST: begin
        if (accept) begin
          beats_left_d = beats_left_q - ONE;
          if (beats_left_q == ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response steering follows the head tag; a beat with no tag is dropped and flagged
  always_comb begin
    head_port = fifo_port_q[rd_ptr_q[PTR_W-1:0]];
    head_len  = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
    rsp_valid = reset_n & m.readdatavalid & ~fifo_empty;
    pop       = rsp_valid & ((rsp_cnt_q + ONE) == head_len);
    rsp_cnt_d = rsp_cnt_q;
    if (pop)            rsp_cnt_d = '0;
    else if (rsp_valid) rsp_cnt_d = rsp_cnt_q + ONE;
    err_d    = err_q | (m.readdatavalid & fifo_empty);
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

    a0.readdatavalid = rsp_valid & ~head_port;
    a1.readdatavalid = rsp_valid &  head_port;
    a0.readdata      = m.readdata;
    a1.readdata      = m.readdata;
    err_orphan_rsp   = err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      beats_left_q <= '0;
      rsp_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      beats_left_q <= beats_left_d;
      rsp_cnt_q    <= rsp_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_port_q[wr_ptr_q[PTR_W-1:0]] <= gsel;
      fifo_len_q[wr_ptr_q[PTR_W-1:0]]  <= sel_burstcount;
    end
  end

endmodule

// File: tb/tb_avalon_mem_if_arbiter.sv
// Directed testbench for avalon_mem_if_arbiter: command scoreboard for write data,
// response-owner scoreboard for read beats, tag-FIFO full/stall and orphan-response checks.
module tb_avalon_mem_if_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 27;
  localparam int BW    = 7;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_orphan_rsp;

  int checks   = 0;
  int failures = 0;
  int rsp_q[$];
  logic [DW-1:0] wdata_q[$];

  avalon_mem_if_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW)) a0_bus ();
  avalon_mem_if_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW)) a1_bus ();
  avalon_mem_if_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW)) m_bus ();

  avalon_mem_if_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW), .RD_TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .a0(a0_bus),
    .a1(a1_bus),
    .m(m_bus),
    .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input int port, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                               input logic [DW-1:0] data);
    if (port == 0) begin
      a0_bus.read = rd; a0_bus.write = wr; a0_bus.address = addr;
      a0_bus.burstcount = bc; a0_bus.writedata = data; a0_bus.byteenable = '1;
    end else begin
      a1_bus.read = rd; a1_bus.write = wr; a1_bus.address = addr;
      a1_bus.burstcount = bc; a1_bus.writedata = data; a1_bus.byteenable = '1;
    end
  endtask

  // One memory read beat; the owner expected is the oldest entry in the scoreboard
  task automatic respond(input string tag);
    int exp_port;
    logic [DW-1:0] d;
    d = $urandom;
    exp_port = (rsp_q.size() > 0) ? rsp_q.pop_front() : -1;
    m_bus.readdatavalid = 1'b1;
    m_bus.readdata = d;
    settle();
    checkOutput({tag, "_a0rdv"}, a0_bus.readdatavalid, exp_port == 0);
    checkOutput({tag, "_a1rdv"}, a1_bus.readdatavalid, exp_port == 1);
    checkOutput({tag, "_rdata"}, exp_port == 1 ? a1_bus.readdata : a0_bus.readdata, d);
    tick();
    m_bus.readdatavalid = 1'b0;
  endtask

  initial begin
    int beats;
    int cyc;
    int exp_port;
    logic [DW-1:0] exp_data;
    logic rr_en;
`ifdef AVALON_MEM_ARB_ROUND_ROBIN_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif

    applyStimulus(0, 1'b1, 1'b0, '0, 7'd1, '0);
    applyStimulus(1, 1'b0, 1'b1, '0, 7'd1, '0);
    m_bus.waitrequest = 1'b0;
    m_bus.readdata = '0;
    m_bus.readdatavalid = 1'b1;
    #12;
    checkOutput("rst_mread", m_bus.read, 1'b0);
    checkOutput("rst_mwrite", m_bus.write, 1'b0);
    checkOutput("rst_a0wait", a0_bus.waitrequest, 1'b1);
    checkOutput("rst_a1wait", a1_bus.waitrequest, 1'b1);
    checkOutput("rst_a0rdv", a0_bus.readdatavalid, 1'b0);
    checkOutput("rst_a1rdv", a1_bus.readdatavalid, 1'b0);
    checkOutput("rst_err", err_orphan_rsp, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, '0, 7'd1, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, 7'd1, '0);
    m_bus.readdatavalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("[TB] back-to-back single-beat reads");
    applyStimulus(0, 1'b1, 1'b0, 27'h10, 7'd1, '0);
    settle();
    checkOutput("t1_mread", m_bus.read, 1'b1);
    checkOutput("t1_addr0", m_bus.address, 27'h10);
    checkOutput("t1_a0wait", a0_bus.waitrequest, 1'b0);
    rsp_q.push_back(0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, 7'd1, '0);
    applyStimulus(1, 1'b1, 1'b0, 27'h20, 7'd1, '0);
    settle();
    checkOutput("t1_addr1", m_bus.address, 27'h20);
    checkOutput("t1_a1wait", a1_bus.waitrequest, 1'b0);
    rsp_q.push_back(1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, 7'd1, '0);
    respond("t1_d0");
    respond("t1_d1");

    $display("[TB] locked write burst against competing writer");
    for (int i = 0; i < 4; i++) wdata_q.push_back(DW'(32'hA0 + i));
    wdata_q.push_back(32'hB1);
    applyStimulus(1, 1'b0, 1'b1, 27'h200, 7'd1, 32'hB1);
    beats = 0;
    cyc = 0;
    while (beats < 4 && cyc < 60) begin
      applyStimulus(0, 1'b0, 1'b1, 27'h100, 7'd4, DW'(32'hA0 + beats));
      m_bus.waitrequest = 1'($urandom_range(0, 1));
      settle();
      checkOutput("t2_a1wait", a1_bus.waitrequest, 1'b1);
      checkOutput("t2_mwrite", m_bus.write, 1'b1);
      checkOutput("t2_addr", m_bus.address, 27'h100);
      if (!m_bus.waitrequest) begin
        exp_data = wdata_q.pop_front();
        checkOutput("t2_wdata", m_bus.writedata, exp_data);
        beats++;
      end
      tick();
      cyc++;
    end
    checkOutput("t2_beats", beats, 4);
    applyStimulus(0, 1'b0, 1'b0, '0, 7'd1, '0);
    m_bus.waitrequest = 1'b0;
    settle();
    checkOutput("t2_a1_mwrite", m_bus.write, 1'b1);
    checkOutput("t2_a1_addr", m_bus.address, 27'h200);
    checkOutput("t2_a1_wait", a1_bus.waitrequest, 1'b0);
    exp_data = (wdata_q.size() > 0) ? wdata_q.pop_front() : '0;
    checkOutput("t2_a1_wdata", m_bus.writedata, exp_data);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, 7'd1, '0);

    $display("[TB] contending reads until the tag FIFO fills");
    applyStimulus(0, 1'b1, 1'b0, 27'h300, 7'd1, '0);
    applyStimulus(1, 1'b1, 1'b0, 27'h400, 7'd1, '0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_port = rr_en ? (i % 2) : 0;
      settle();
      checkOutput("t3_grant_addr", m_bus.address, exp_port == 1 ? 27'h400 : 27'h300);
      checkOutput("t3_grant_wait", exp_port == 1 ? a1_bus.waitrequest : a0_bus.waitrequest, 1'b0);
      rsp_q.push_back(exp_port);
      tick();
    end
    settle();
    checkOutput("t3_full_a0wait", a0_bus.waitrequest, 1'b1);
    checkOutput("t3_full_a1wait", a1_bus.waitrequest, 1'b1);
    checkOutput("t3_full_mread", m_bus.read, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 27'h500, 7'd1, 32'hC5);
    settle();
    checkOutput("t3_wr_past_stall", m_bus.write, 1'b1);
    checkOutput("t3_wr_addr", m_bus.address, 27'h500);
    checkOutput("t3_wr_a1wait", a1_bus.waitrequest, 1'b0);
    checkOutput("t3_wr_a0wait", a0_bus.waitrequest, 1'b1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, 7'd1, '0);
    respond("t4_pop");
    settle();
    checkOutput("t4_after_pop_wait", a0_bus.waitrequest, 1'b0);
    checkOutput("t4_after_pop_mread", m_bus.read, 1'b1);
    checkOutput("t4_after_pop_addr", m_bus.address, 27'h300);
    rsp_q.push_back(0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, 7'd1, '0);
    cyc = 0;
    while (rsp_q.size() > 0 && cyc < 10) begin
      respond("t4_drain");
      cyc++;
    end
    checkOutput("t4_drained", rsp_q.size(), 0);

    $display("[TB] burst read responses split between owners");
    applyStimulus(0, 1'b1, 1'b0, 27'h600, 7'd3, '0);
    settle();
    checkOutput("t5_a0wait", a0_bus.waitrequest, 1'b0);
    for (int i = 0; i < 3; i++) rsp_q.push_back(0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, 7'd1, '0);
    applyStimulus(1, 1'b1, 1'b0, 27'h700, 7'd2, '0);
    settle();
    checkOutput("t5_a1wait", a1_bus.waitrequest, 1'b0);
    checkOutput("t5_a1_bc", m_bus.burstcount, 7'd2);
    for (int i = 0; i < 2; i++) rsp_q.push_back(1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, 7'd1, '0);
    for (int i = 0; i < 5; i++) respond("t5_beat");
    checkOutput("t5_err_before", err_orphan_rsp, 1'b0);

    $display("[TB] orphan response");
    m_bus.readdatavalid = 1'b1;
    settle();
    checkOutput("t6_a0rdv", a0_bus.readdatavalid, 1'b0);
    checkOutput("t6_a1rdv", a1_bus.readdatavalid, 1'b0);
    tick();
    m_bus.readdatavalid = 1'b0;
    settle();
    checkOutput("t6_err_set", err_orphan_rsp, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("t6_err_sticky", err_orphan_rsp, 1'b1);
    reset_n = 1'b0;
    settle();
    checkOutput("t6_err_cleared", err_orphan_rsp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
